// File: rtl/ser_sched_pkg.sv
// rtl/ser_sched_pkg.sv - shared state encoding and parameter defaults for ser_sched
// Purpose: FSM state enum, legacy-compatible state constants and default
//          parameter values shared by ser_sched, its interface and rr_arbiter.
// Ports:   none (package).
package ser_sched_pkg;

  localparam int NREQ_DEF      = 4;
  localparam int DATAWIDTH_DEF = 8;
  localparam int START_TMO_DEF = 4;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LOAD       = 2'd1,
    WAIT_START = 2'd2,
    WAIT_END   = 2'd3
  } state_e;

  localparam logic [1:0] ST_IDLE       = IDLE;
  localparam logic [1:0] ST_LOAD       = LOAD;
  localparam logic [1:0] ST_WAIT_START = WAIT_START;
  localparam logic [1:0] ST_WAIT_END   = WAIT_END;

endpackage

// File: rtl/ser_sched_if.sv
// rtl/ser_sched_if.sv - requester and serializer signal bundle for ser_sched
// Purpose: groups the requester handshake and the shared-serializer signals.
// Ports:   master modport is the scheduler side (drives o_*),
//          slave modport is the requester/serializer side (drives i_*).
//          i_Req/i_Data     per-requester pending flag and parallel word
//          o_Ack            one-hot capture pulse back to the requester
//          o_SerData/Load   word and load strobe to the serializer
//          i_SerValid       serializer serial-output valid
//          o_ActiveId/Busy/Done/Err  ownership and completion status
interface ser_sched_if
  import ser_sched_pkg::*;
#(
  parameter int NREQ      = NREQ_DEF,
  parameter int DATAWIDTH = DATAWIDTH_DEF
) ();

  logic [NREQ-1:0]                i_Req;
  logic [NREQ-1:0][DATAWIDTH-1:0] i_Data;
  logic [NREQ-1:0]                o_Ack;
  logic [DATAWIDTH-1:0]           o_SerData;
  logic                           o_SerLoad;
  logic                           i_SerValid;
  logic [$clog2(NREQ)-1:0]        o_ActiveId;
  logic                           o_Busy;
  logic                           o_Done;
  logic                           o_Err;

  modport master (
    input  i_Req, i_Data, i_SerValid,
    output o_Ack, o_SerData, o_SerLoad, o_ActiveId, o_Busy, o_Done, o_Err
  );

  modport slave (
    output i_Req, i_Data, i_SerValid,
    input  o_Ack, o_SerData, o_SerLoad, o_ActiveId, o_Busy, o_Done, o_Err
  );

endinterface

// File: rtl/ser_sched_rr_arbiter.sv
// rtl/ser_sched_rr_arbiter.sv - combinational round-robin grant for ser_sched
// Purpose: picks the first set request at or after ptr, wrapping NREQ-1 -> 0.
// Ports:   req   pending requests
//          ptr   search start index
//          grant one-hot winner (zero when no request)
//          index binary index of the winner
//          any   at least one request pending
module rr_arbiter
  import ser_sched_pkg::*;
#(
  parameter int NREQ = NREQ_DEF
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] index,
  output logic                    any
);

  localparam int IDW = $clog2(NREQ);

  logic           found;
  logic [IDW-1:0] idx;

  always_comb begin
    grant = '0;
    index = '0;
    found = 1'b0;
    idx   = '0;
    any   = |req;
    for (int k = 0; k < NREQ; k++) begin
      idx = IDW'((int'(ptr) + k) % NREQ);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        index      = idx;
      end
    end
  end

endmodule

// File: rtl/ser_sched.sv
// rtl/ser_sched.sv - round-robin scheduler sharing one parallel-to-serial serializer
// Purpose: arbitrates NREQ requesters onto a single serializer, loads the
//          winner's word, supervises serializer start (timeout) and end.
// Ports:   clk   rising-edge clock
//          rstn  synchronous active-low reset
//          bus   ser_sched_if.master (requesters + serializer + status)
module ser_sched
  import ser_sched_pkg::*;
#(
  parameter int NREQ      = NREQ_DEF,
  parameter int DATAWIDTH = DATAWIDTH_DEF,
  parameter int START_TMO = START_TMO_DEF
) (
  input  logic        clk,
  input  logic        rstn,
  ser_sched_if.master bus
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(START_TMO + 1);

  logic [1:0]           state_q, state_d;
  logic [IDW-1:0]       ptr_q, ptr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DATAWIDTH-1:0] word_q, word_d;
  logic [IDW-1:0]       id_q, id_d;
  logic [NREQ-1:0]      ack_q, ack_d;
  logic                 load_q, load_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic [NREQ-1:0]      grant;
  logic [IDW-1:0]       grant_idx;
  logic                 grant_any;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req   (bus.i_Req),
    .ptr   (ptr_q),
    .grant (grant),
    .index (grant_idx),
    .any   (grant_any)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    id_d    = id_q;
    ack_d   = '0;
    load_d  = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // The first IDLE cycle after a Done/Err is a settle cycle: requests are
        // re-sampled only on the following cycle, so loads stay two cycles
        // behind completion and the serializer has time to fall idle.
        if (grant_any && !done_q && !err_q) begin
          word_d  = bus.i_Data[grant_idx];
          id_d    = grant_idx;
          ptr_d   = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
          ack_d   = grant;
          load_d  = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        cnt_d   = '0;
        state_d = ST_WAIT_START;
      end
      ST_WAIT_START: begin
        // Valid takes priority over the timeout on the same cycle.
        if (bus.i_SerValid) begin
          state_d = ST_WAIT_END;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(START_TMO - 1)) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_WAIT_END: begin
        if (!bus.i_SerValid) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      id_q    <= '0;
      ack_q   <= '0;
      load_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      id_q    <= id_d;
      ack_q   <= ack_d;
      load_q  <= load_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.o_Ack      = ack_q;
  assign bus.o_SerData  = word_q;
  assign bus.o_SerLoad  = load_q;
  assign bus.o_ActiveId = id_q;
  assign bus.o_Busy     = busy_q;
  assign bus.o_Done     = done_q;
  assign bus.o_Err      = err_q;

endmodule
